uart_baud_gen: RTL and testbench

//  Programmable UART baud/oversample tick generator; next generation of the fixed-divisor sampler.

---
 rtl/uart_baud_gen.sv | 158 +++++++++++++++
 tb/tb_uart_baud_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// Programmable UART baud / oversample tick generator with glitch-free divisor update and
// start-bit resync. Optional fractional divisor accumulator enabled by `define UART_BAUD_FRAC_EN.
module uart_baud_gen #(
  parameter int                DIV_W        = 16,
  parameter int                OVS          = 16,
  parameter int                FRAC_W       = 4,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV  = DIV_W'(32),
  parameter logic [FRAC_W-1:0] DEFAULT_FRAC = FRAC_W'(9)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_En,
  input  logic              i_Sync,
  input  logic              i_Div_Wr,
  input  logic [DIV_W-1:0]  i_Div,
  input  logic [FRAC_W-1:0] i_Div_Frac,
  output logic              o_Rx_Tick,
  output logic              o_Tx_Tick,
  output logic              o_Mid_Tick,
  output logic              o_Div_Pend
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OVS_W-1:0] ovs_cnt_q, ovs_cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_shd_q, div_shd_d;
  logic             pend_q, pend_d;
  logic             rx_q, rx_d;
  logic             tx_q, tx_d;
  logic             mid_q, mid_d;

  logic             carry;
  logic [DIV_W:0]   last_cnt;
  logic             wrap;
  logic             apply;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_act_q, frac_act_d;
  logic [FRAC_W-1:0] frac_shd_q, frac_shd_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;

  // A carry out of the accumulator stretches the current period by one clock.
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_act_q};
  assign carry   = acc_sum[FRAC_W];
`else
  logic unused_frac;
  assign unused_frac = ^{i_Div_Frac, DEFAULT_FRAC};
  assign carry       = 1'b0;
`endif

  // Divisor 0 behaves as 1, so the terminal count never underflows.
  assign last_cnt = ((div_act_q == '0) ? '0 : ({1'b0, div_act_q} - (DIV_W+1)'(1)))
                  + {{DIV_W{1'b0}}, carry};
  assign wrap     = i_En && !i_Sync && ({1'b0, div_cnt_q} >= last_cnt);
  assign apply    = pend_q && (wrap || !i_En || i_Sync);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    div_cnt_d = div_cnt_q;
    ovs_cnt_d = ovs_cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    pend_d    = pend_q;
    rx_d      = 1'b0;
    tx_d      = 1'b0;
    mid_d     = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    frac_act_d = frac_act_q;
    frac_shd_d = frac_shd_q;
    acc_d      = acc_q;
`endif

    if (i_Sync) begin
      div_cnt_d = '0;
      ovs_cnt_d = '0;
`ifdef UART_BAUD_FRAC_EN
      acc_d     = '0;
`endif
    end else if (wrap) begin
      div_cnt_d = '0;
      ovs_cnt_d = ovs_cnt_q + 1'b1;
      rx_d      = 1'b1;
      tx_d      = (ovs_cnt_q == OVS_LAST);
      mid_d     = (ovs_cnt_q == OVS_MID);
`ifdef UART_BAUD_FRAC_EN
      acc_d     = acc_sum[FRAC_W-1:0];
`endif
    end else if (i_En) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    // The old shadow is applied before a same-cycle write replaces it.
    if (apply) begin
      div_act_d = div_shd_q;
      pend_d    = 1'b0;
`ifdef UART_BAUD_FRAC_EN
      frac_act_d = frac_shd_q;
      acc_d      = '0;
`endif
    end

    if (i_Div_Wr) begin
      div_shd_d = i_Div;
      pend_d    = 1'b1;
`ifdef UART_BAUD_FRAC_EN
      frac_shd_d = i_Div_Frac;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      ovs_cnt_q <= '0;
      div_act_q <= DEFAULT_DIV;
      div_shd_q <= DEFAULT_DIV;
      pend_q    <= 1'b0;
      rx_q      <= 1'b0;
      tx_q      <= 1'b0;
      mid_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ovs_cnt_q <= ovs_cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      pend_q    <= pend_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      mid_q     <= mid_d;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frac_act_q <= DEFAULT_FRAC;
      frac_shd_q <= DEFAULT_FRAC;
      acc_q      <= '0;
    end else begin
      frac_act_q <= frac_act_d;
      frac_shd_q <= frac_shd_d;
      acc_q      <= acc_d;
    end
  end
`endif

  assign o_Rx_Tick  = rx_q;
  assign o_Tx_Tick  = tx_q;
  assign o_Mid_Tick = mid_q;
  assign o_Div_Pend = pend_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios plus randomized stimulus compared
// cycle by cycle against a period-length reference model.
module tb_uart_baud_gen;

  localparam int OVS  = 16;
  localparam int FMOD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, sync, wr;
  logic [15:0] div;
  logic [3:0]  frac;
  logic        rx_tick, tx_tick, mid_tick, div_pend;

  uart_baud_gen dut (
    .clk        (clk),
    .reset      (reset),
    .i_En       (en),
    .i_Sync     (sync),
    .i_Div_Wr   (wr),
    .i_Div      (div),
    .i_Div_Frac (frac),
    .o_Rx_Tick  (rx_tick),
    .o_Tx_Tick  (tx_tick),
    .o_Mid_Tick (mid_tick),
    .o_Div_Pend (div_pend)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: elapsed clocks in the current period versus its required length.
  int m_elapsed, m_idx, m_act, m_shd, m_frac_act, m_frac_shd, m_acc;
  bit m_pend, x_rx, x_tx, x_mid;
  int cyc;
  int rx_cycles[$];
  int tx_cycles[$];
  int first_mid, first_tx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0; m_idx = 0; m_acc = 0;
    m_act = 32; m_shd = 32; m_frac_act = 9; m_frac_shd = 9;
    m_pend = 0; x_rx = 0; x_tx = 0; x_mid = 0;
    cyc = 0; first_mid = -1; first_tx = -1;
    rx_cycles.delete();
    tx_cycles.delete();
  endtask

  task automatic model_step();
    int  len;
    bit  tick;
    bit  apply;
    tick = 0; x_rx = 0; x_tx = 0; x_mid = 0;
    if (sync) begin
      m_elapsed = 0; m_idx = 0; m_acc = 0;
    end else if (en) begin
      len = (m_act == 0) ? 1 : m_act;
`ifdef UART_BAUD_FRAC_EN
      if (m_acc + m_frac_act >= FMOD) len++;
`endif
      m_elapsed++;
      if (m_elapsed >= len) begin
        tick  = 1;
        x_rx  = 1;
        x_tx  = (m_idx == OVS - 1);
        x_mid = (m_idx == OVS / 2 - 1);
        m_idx = (m_idx + 1) % OVS;
        m_elapsed = 0;
        m_acc = (m_acc + m_frac_act) % FMOD;
      end
    end
    apply = m_pend && (sync || !en || tick);
    if (apply) begin
      m_act = m_shd; m_frac_act = m_frac_shd; m_acc = 0;
    end
    if (wr) begin
      m_shd = div; m_frac_shd = frac; m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
    cyc++;
    if (x_rx) rx_cycles.push_back(cyc);
    if (x_tx) tx_cycles.push_back(cyc);
    if (x_mid && first_mid < 0) first_mid = cyc;
    if (x_tx && first_tx < 0) first_tx = cyc;
  endtask

  // mode 0 idle run, 1 random, 2 write DIV=10 at 40, 3 DIV 0 then 1, 4 sync at 100, 5 en low 40..44
  task automatic drive(input int mode);
    en = 1'b1; sync = 1'b0; wr = 1'b0; div = 16'd0; frac = 4'd0;
    case (mode)
      1: begin
        en   = ($urandom_range(0, 9) != 0);
        sync = ($urandom_range(0, 59) == 0);
        wr   = ($urandom_range(0, 29) == 0);
        div  = 16'($urandom_range(0, 12));
        frac = 4'($urandom);
      end
      2: begin wr = (cyc == 40); div = 16'd10; end
      3: begin wr = (cyc == 1 || cyc == 100); div = (cyc == 1) ? 16'd0 : 16'd1; end
      4: sync = (cyc == 100);
      5: en = !(cyc >= 40 && cyc <= 44);
      default: ;
    endcase
  endtask

  // Entered and left at a falling edge.
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      check("rx",   rx_tick,  x_rx);
      check("tx",   tx_tick,  x_tx);
      check("mid",  mid_tick, x_mid);
      check("pend", div_pend, m_pend);
      drive(mode);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_rx",   rx_tick,  1'b0);
    check("rst_tx",   tx_tick,  1'b0);
    check("rst_mid",  mid_tick, 1'b0);
    check("rst_pend", div_pend, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b0; sync = 1'b0; wr = 1'b0; div = 16'd0; frac = 4'd0;
    model_reset();
    @(negedge clk);
    check("por_rx",   rx_tick,  1'b0);
    check("por_pend", div_pend, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Default divisor after reset
    run(600, 0);
`ifdef UART_BAUD_FRAC_EN
    check("frac_16_ticks", rx_cycles[15], 521);
`else
    check("first_rx",  rx_cycles[0], 32);
    check("second_rx", rx_cycles[1], 64);
    check("first_mid", first_mid, 256);
    check("first_tx",  first_tx, 512);

    // Runtime divisor write finishes the old period first
    async_reset();
    run(100, 2);
    check("wr_rx2", rx_cycles[1], 64);
    check("wr_rx3", rx_cycles[2], 74);
    check("wr_rx4", rx_cycles[3], 84);

    // Divisor 0 then 1: tick every cycle, tx every 16
    async_reset();
    run(200, 3);
    check("div01_rx_step", rx_cycles[$] - rx_cycles[$-1], 1);
    check("div01_tx_step", tx_cycles[$] - tx_cycles[$-1], 16);

    // Sync realignment
    async_reset();
    run(400, 4);
    check("sync_rx3",   rx_cycles[3], 133);
    check("sync_mid",   first_mid, 357);

    // Enable held low for 5 cycles
    async_reset();
    run(120, 5);
    check("en_rx2", rx_cycles[1], 69);
    check("en_rx3", rx_cycles[2], 101);
`endif

    // Pending write discarded by reset, restart on default divisor
    async_reset();
    run(50, 2);
    check("pend_before_rst", div_pend, 1'b1);
    async_reset();
    run(40, 0);
    check("rst_restart_rx", rx_cycles[0], 32);

    // Randomized stimulus with periodic mid-operation resets
    for (int k = 0; k < 4; k++) begin
      async_reset();
      run(4000, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
